pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. Drives load enables and bubble-insert (flush) controls of the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves three hazards: a data-memory wait on loads and stores sitting in EX_MEM, a branch or jump redirect resolved in EX_MEM, and a load-use dependency between ID_EX and IF_ID. It also keeps a stall-cycle counter and a sticky memory-timeout error.

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/pipeline_ctrl_hazard_detect.sv | 19 +
 rtl/pipeline_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control types: sequencer states, the zero register index,
// and the per-stage {en, flush} control pair.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use compare: the load in EX writes a register the instruction in ID reads.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] i_if_id_rs,
    input  logic [4:0] i_if_id_rt,
    input  logic [4:0] i_id_ex_rt,
    input  logic       i_id_ex_memtoreg,
    output logic       o_hazard
);

    logic w_dest_live;
    logic w_src_match;

    assign w_dest_live = i_id_ex_memtoreg && (i_id_ex_rt != REG_ZERO);
    assign w_src_match = (i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt);
    assign o_hazard    = w_dest_live && w_src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait, redirect and
// load-use resolution, stall-cycle counter and sticky memory-timeout error.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       if_id_rs_i,
    input  logic [4:0]       if_id_rt_i,
    input  logic [4:0]       id_ex_rt_i,
    input  logic             id_ex_memtoreg_i,
    input  logic             ex_mem_isbranch_i,
    input  logic             ex_mem_zero_i,
    input  logic             ex_mem_isjump_i,
    input  logic             ex_mem_memwrite_i,
    input  logic             ex_mem_memtoreg_i,
    input  logic             dmem_ready_i,
    output logic             dmem_req_o,
    output logic             redirect_o,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_e             r_state;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_err;

    logic        w_hazard;
    logic        w_mem_op;
    logic        w_taken;
    logic        w_active;
    logic        w_mem_stall;
    logic        w_redirect;
    logic        w_load_use;
    logic        w_pc_en;
    stage_ctrl_t w_if_id;
    stage_ctrl_t w_id_ex;
    stage_ctrl_t w_ex_mem;
    stage_ctrl_t w_mem_wb;

    hazard_detect u_hazard_detect (
        .i_if_id_rs       (if_id_rs_i),
        .i_if_id_rt       (if_id_rt_i),
        .i_id_ex_rt       (id_ex_rt_i),
        .i_id_ex_memtoreg (id_ex_memtoreg_i),
        .o_hazard         (w_hazard)
    );

    always_comb begin
        w_mem_op = ex_mem_memwrite_i | ex_mem_memtoreg_i;
        w_taken  = (ex_mem_isbranch_i & ex_mem_zero_i) | ex_mem_isjump_i;
        w_active = (r_state != ERR);

        // Once waiting, only ready releases the stall; the held EX_MEM op is implied.
        w_mem_stall = 1'b0;
        if (r_state == MEM_WAIT) begin
            w_mem_stall = !dmem_ready_i;
        end else if (r_state == RUN) begin
            w_mem_stall = w_mem_op && !dmem_ready_i;
        end

        w_redirect = w_active && !w_mem_stall && w_taken;
        w_load_use = w_active && !w_mem_stall && !w_taken && w_hazard;

        w_pc_en  = w_active;
        w_if_id  = '{en: w_active, flush: 1'b0};
        w_id_ex  = '{en: w_active, flush: 1'b0};
        w_ex_mem = '{en: w_active, flush: 1'b0};
        w_mem_wb = '{en: w_active, flush: 1'b0};

        if (w_mem_stall) begin
            w_pc_en        = 1'b0;
            w_if_id.en     = 1'b0;
            w_id_ex.en     = 1'b0;
            w_ex_mem.en    = 1'b0;
            w_mem_wb.flush = 1'b1;
        end else if (w_redirect) begin
            w_if_id.flush  = 1'b1;
            w_id_ex.flush  = 1'b1;
            w_ex_mem.flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_if_id.en    = 1'b0;
            w_id_ex.flush = 1'b1;
        end
    end

    // Reset forces every stage to bubble regardless of the registered state.
    assign dmem_req_o     = rst_n_i && w_active && w_mem_op;
    assign redirect_o     = rst_n_i && w_redirect;
    assign pc_en_o        = rst_n_i && w_pc_en;
    assign if_id_en_o     = rst_n_i && w_if_id.en;
    assign id_ex_en_o     = rst_n_i && w_id_ex.en;
    assign ex_mem_en_o    = rst_n_i && w_ex_mem.en;
    assign mem_wb_en_o    = rst_n_i && w_mem_wb.en;
    assign if_id_flush_o  = !rst_n_i || w_if_id.flush;
    assign id_ex_flush_o  = !rst_n_i || w_id_ex.flush;
    assign ex_mem_flush_o = !rst_n_i || w_ex_mem.flush;
    assign mem_wb_flush_o = !rst_n_i || w_mem_wb.flush;
    assign stall_cnt_o    = r_stall_cnt;
    assign err_o          = r_err;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= RUN;
            r_wait      <= '0;
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state <= MEM_WAIT;
                        r_wait  <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready_i) begin
                        r_state <= RUN;
                    end else if (r_wait == WAIT_LAST) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ERR: begin
                    r_state <= ERR;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase

            if ((w_mem_stall || w_load_use) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and random checks of pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int MAXW    = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [4:0]    rs, rt, ex_rt;
    logic          ex_load, br, zero, jmp, mw, mtr, rdy;
    logic          dmem_req, redirect, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl;
    logic [CW-1:0] stall_cnt;
    logic          err;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: are we inside a memory wait, how many no-ready wait cycles so far,
    // sticky error, and the saturating stall count.
    bit m_wait;
    bit m_err;
    int m_waits;
    int m_cnt;

    pipeline_ctrl #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .if_id_rs_i        (rs),
        .if_id_rt_i        (rt),
        .id_ex_rt_i        (ex_rt),
        .id_ex_memtoreg_i  (ex_load),
        .ex_mem_isbranch_i (br),
        .ex_mem_zero_i     (zero),
        .ex_mem_isjump_i   (jmp),
        .ex_mem_memwrite_i (mw),
        .ex_mem_memtoreg_i (mtr),
        .dmem_ready_i      (rdy),
        .dmem_req_o        (dmem_req),
        .redirect_o        (redirect),
        .pc_en_o           (pc_en),
        .if_id_en_o        (if_id_en),
        .id_ex_en_o        (id_ex_en),
        .ex_mem_en_o       (ex_mem_en),
        .mem_wb_en_o       (mem_wb_en),
        .if_id_flush_o     (if_id_fl),
        .id_ex_flush_o     (id_ex_fl),
        .ex_mem_flush_o    (ex_mem_fl),
        .mem_wb_flush_o    (mem_wb_fl),
        .stall_cnt_o       (stall_cnt),
        .err_o             (err)
    );

    // {req, redirect, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, 4 x flush}
    function automatic logic [10:0] observed();
        return {dmem_req, redirect, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl};
    endfunction

    function automatic bit stalled_on_mem();
        if (m_wait) return !rdy;
        return (mw || mtr) && !rdy;
    endfunction

    function automatic bit load_use();
        return ex_load && (ex_rt != 5'd0) && (ex_rt == rs || ex_rt == rt);
    endfunction

    function automatic bit taken();
        return (br && zero) || jmp;
    endfunction

    function automatic logic [10:0] expected();
        logic req, red, pc, e1, e2, e3, e4, f1, f2, f3, f4;
        if (!rst_n) return 11'b00000001111;
        if (m_err) return 11'b0;
        req = mw || mtr;
        red = 0; pc = 1; e1 = 1; e2 = 1; e3 = 1; e4 = 1;
        f1 = 0; f2 = 0; f3 = 0; f4 = 0;
        if (stalled_on_mem()) begin
            pc = 0; e1 = 0; e2 = 0; e3 = 0; f4 = 1;
        end else if (taken()) begin
            red = 1; f1 = 1; f2 = 1; f3 = 1;
        end else if (load_use()) begin
            pc = 0; e1 = 0; f2 = 1;
        end
        return {req, red, pc, e1, e2, e3, e4, f1, f2, f3, f4};
    endfunction

    function automatic int bump(input int c);
        return (c < CNT_MAX) ? c + 1 : c;
    endfunction

    task automatic model_step();
        if (!m_err) begin
            if (stalled_on_mem()) begin
                m_cnt = bump(m_cnt);
                if (m_wait) begin
                    m_waits++;
                    if (m_waits == MAXW) begin
                        m_err  = 1;
                        m_wait = 0;
                    end
                end else begin
                    m_wait  = 1;
                    m_waits = 0;
                end
            end else begin
                m_wait = 0;
                if (!taken() && load_use()) m_cnt = bump(m_cnt);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a_rs, a_rt, a_exrt,
                         input logic a_load, a_br, a_zero, a_jmp, a_mw, a_mtr, a_rdy);
        rs = a_rs; rt = a_rt; ex_rt = a_exrt; ex_load = a_load;
        br = a_br; zero = a_zero; jmp = a_jmp; mw = a_mw; mtr = a_mtr; rdy = a_rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Caller sits just after a rising edge with inputs applied.
    task automatic cycle(input string tag);
        #3;
        chk({tag, "/ctl"}, 32'(observed()), 32'(expected()));
        model_step();
        @(posedge clk);
        #1;
        chk({tag, "/cnt"}, 32'(stall_cnt), 32'(m_cnt));
        chk({tag, "/err"}, 32'(err), 32'(m_err));
    endtask

    task automatic async_reset(input string tag);
        drive(5'd3, 5'd3, 5'd3, 1, 1, 1, 1, 0, 1, 0);
        rst_n = 0;
        #2;
        m_wait = 0; m_err = 0; m_waits = 0; m_cnt = 0;
        chk({tag, "/rst_ctl"}, 32'(observed()), 32'(expected()));
        chk({tag, "/rst_cnt"}, 32'(stall_cnt), 32'(m_cnt));
        chk({tag, "/rst_err"}, 32'(err), 32'(m_err));
        @(posedge clk);
        #1;
        chk({tag, "/rst_hold"}, 32'(observed()), 32'(expected()));
        rst_n = 1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        m_wait = 0; m_err = 0; m_waits = 0; m_cnt = 0;
        idle();
        #12;
        chk("reset/ctl", 32'(observed()), 32'(11'b00000001111));
        chk("reset/cnt", 32'(stall_cnt), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1;
        cycle("post_reset");
        chk("post_reset/normal", 32'(observed()), 32'(11'b00111110000));

        drive(5'd8, 5'd0, 5'd8, 1, 0, 0, 0, 0, 0, 1);
        cycle("load_use");
        chk("load_use/cnt1", 32'(stall_cnt), 32'(1));
        idle();                                    cycle("lu_after");
        drive(5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, 1); cycle("lu_rt_zero");
        drive(5'd1, 5'd9, 5'd9, 1, 0, 0, 0, 0, 0, 1); cycle("lu_rt_match");

        drive(5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, 0, 1); cycle("branch_taken");
        drive(5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, 1); cycle("branch_not");
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 1); cycle("jump");

        async_reset("rst_a");
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle("memwait");
        rdy = 1;                                   cycle("mem_ready");
        chk("memwait/cnt3", 32'(stall_cnt), 32'(3));
        idle();                                    cycle("mem_after");

        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i <= MAXW - 1; i++) cycle("boundary_wait");
        rdy = 1;                                   cycle("boundary_ready");
        chk("boundary/no_err", 32'(err), 32'(0));

        async_reset("rst_b");
        drive(5'd8, 5'd0, 5'd8, 1, 1, 1, 0, 1, 0, 0);
        cycle("prio_stall0");
        cycle("prio_stall1");
        rdy = 1;                                   cycle("prio_ready");
        idle();                                    cycle("prio_after");

        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i <= MAXW; i++) cycle("timeout");
        chk("timeout/err", 32'(err), 32'(1));
        idle();                                    cycle("err_sticky0");
        drive(5'd8, 5'd0, 5'd8, 1, 0, 0, 1, 0, 1, 1); cycle("err_sticky1");
        async_reset("rst_err");
        cycle("err_cleared");

        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0);
        cycle("midwait0");
        cycle("midwait1");
        async_reset("rst_midwait");
        cycle("midwait_run");

        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 49) begin
                async_reset("rand_rst");
            end else begin
                rs      = 5'($urandom_range(0, 3));
                rt      = 5'($urandom_range(0, 3));
                ex_rt   = 5'($urandom_range(0, 3));
                ex_load = 1'($urandom_range(0, 1));
                br      = ($urandom_range(0, 3) == 0);
                zero    = 1'($urandom_range(0, 1));
                jmp     = ($urandom_range(0, 7) == 0);
                rdy     = ($urandom_range(0, 9) < 6);
                if (!m_wait) begin
                    mw  = ($urandom_range(0, 5) == 0);
                    mtr = ($urandom_range(0, 4) == 0);
                end
                cycle("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
